// File: rtl/tag_reclaim.sv
// tag_reclaim: write-side feeder for the physical tag free list.
// After reset it seeds every non-architectural tag into tag_fifo. It then
// buffers up to two retired tags per cycle and drains them one per cycle
// under freespace backpressure.
module tag_reclaim #(
    parameter int TAG_W     = 8,
    parameter int NUM_PHYS  = 64,
    parameter int NUM_ARCH  = 32,
    parameter int BUF_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   retire_valid,
    input  logic [TAG_W-1:0]             retire_tag_0,
    input  logic [TAG_W-1:0]             retire_tag_1,
    output logic                         retire_ready,
    input  logic [7:0]                   freespace,
    output logic [TAG_W-1:0]             write_tag_source,
    output logic                         write_tag,
    output logic                         init_done,
    output logic [$clog2(BUF_DEPTH):0]   pending,
    output logic                         tag_err
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [TAG_W-1:0] SEED_FIRST = TAG_W'(NUM_ARCH);
    localparam logic [TAG_W-1:0] SEED_LAST  = TAG_W'(NUM_PHYS - 1);
    localparam logic [TAG_W:0]   PHYS_LIM   = (TAG_W + 1)'(NUM_PHYS);
    localparam logic [CNT_W-1:0] READY_MAX  = CNT_W'(BUF_DEPTH - 2);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [TAG_W-1:0]   seed_q, seed_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic               ready_q, ready_d;
    logic               wr_q, wr_d;
    logic [TAG_W-1:0]   src_q, src_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [TAG_W-1:0]   mem [BUF_DEPTH];

    logic               can_push;
    logic               legal_0, legal_1;
    logic               enq_0, enq_1;
    logic               drain;
    logic [PTR_W-1:0]   slot1_idx;

    // Next-state, enqueue/drain decisions and registered-output values.
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        head_d   = head_q;
        src_d    = src_q;
        wr_d     = 1'b0;
        done_d   = done_q;
        drain    = 1'b0;

        // A threshold of 2 covers the cycle tag_fifo needs to update freespace.
        can_push = (freespace >= 8'd2);
        legal_0  = ({1'b0, retire_tag_0} < PHYS_LIM);
        legal_1  = ({1'b0, retire_tag_1} < PHYS_LIM);

        // retire_ready is only ever 1 in RUN, so it alone gates acceptance.
        enq_0    = ready_q && retire_valid[0] && legal_0;
        enq_1    = ready_q && retire_valid[1] && legal_1;
        err_d    = err_q || (ready_q && retire_valid[0] && !legal_0)
                         || (ready_q && retire_valid[1] && !legal_1);

        case (state_q)
            S_INIT: begin
                if (can_push) begin
                    wr_d   = 1'b1;
                    src_d  = seed_q;
                    seed_d = seed_q + 1'b1;
                    if (seed_q == SEED_LAST) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Only entries present before this edge may drain: no bypass.
                drain = (occ_q != '0) && can_push;
                if (drain) begin
                    wr_d   = 1'b1;
                    src_d  = mem[head_q];
                    head_d = head_q + 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase

        slot1_idx = tail_q + PTR_W'(enq_0);
        tail_d    = tail_q + PTR_W'(enq_0) + PTR_W'(enq_1);
        occ_d     = occ_q + CNT_W'(enq_0) + CNT_W'(enq_1) - CNT_W'(drain);
        // Uses the current state so ready rises one edge after init_done,
        // and the next occupancy so there is always room for two tags.
        ready_d   = (state_q == S_RUN) && (occ_d <= READY_MAX);
    end

    // Control and output registers with asynchronous reset.
    // NOTE: sequential state is assigned with non-blocking <= only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            seed_q  <= SEED_FIRST;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            src_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            src_q   <= src_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Retire buffer storage; slot 0 lands before slot 1.
    // NOTE: the storage array is not reset; occupancy alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (enq_0) mem[tail_q]    <= retire_tag_0;
        if (enq_1) mem[slot1_idx] <= retire_tag_1;
    end

    assign retire_ready     = ready_q;
    assign write_tag        = wr_q;
    assign write_tag_source = src_q;
    assign init_done        = done_q;
    assign pending          = occ_q;
    assign tag_err          = err_q;

endmodule
